sm3_core_top: RTL and testbench

- Streaming SM3 hash engine (GB/T 32905).
- Accepts a byte-granular message on a 32-bit word bus, performs SM3 padding internally, and compresses each 512-bit block. Presents the 256-bit digest with a one-cycle valid pulse.
- Sits behind the sm3_if interface bundle. Top-level hash block for crypto accelerators; one message in flight at a time.

---
 rtl/sm3_core_top_if.sv | 26 ++
 rtl/sm3_core_top.sv | 179 +++++++++++++++++
 tb/tb_sm3_core_top.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sm3_core_top_if.sv
// Signal bundle between an SM3 message source and the sm3_core_top hash engine.
// The core modport is the engine's view; the source drives the message side.
interface sm3_if (
    input logic clk,
    input logic rst_n
);
    logic [31:0]  msg_inpt_d;
    logic [3:0]   msg_inpt_vld_byte;
    logic         msg_inpt_vld;
    logic         msg_inpt_lst;
    logic         msg_inpt_rdy;
    logic [255:0] cmprss_otpt_res;
    logic         cmprss_otpt_vld;

    modport core (
        input  clk,
        input  rst_n,
        input  msg_inpt_d,
        input  msg_inpt_vld_byte,
        input  msg_inpt_vld,
        input  msg_inpt_lst,
        output msg_inpt_rdy,
        output cmprss_otpt_res,
        output cmprss_otpt_vld
    );
endinterface

// File: rtl/sm3_core_top.sv
// Streaming SM3 hash engine: byte-granular 32-bit input, internal padding,
// one round per cycle compression and a single-cycle digest valid pulse.
module sm3_core_top (
    sm3_if.core bus
);
    typedef enum logic [1:0] {S_LOAD, S_PAD, S_CMPRS, S_DONE} state_t;

    localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
    endfunction

    state_t        state, state_nxt;
    logic [31:0]   blk [16];
    logic [4:0]    widx;
    logic [63:0]   len;
    logic          need80, msg_end, final_blk;
    logic [6:0]    rnd;
    logic [31:0]   v [8];
    logic [31:0]   r [8];
    logic [255:0]  res;
    logic          res_vld;

    logic          accept;
    logic [31:0]   in_word;
    logic [3:0]    in_bytes;
    logic [5:0]    pad_end;
    logic          pad_final;
    logic [31:0]   tj, ss1, ss2, ff, gg, tt1, tt2, w_new;

    assign accept    = bus.msg_inpt_vld && (state == S_LOAD);
    assign pad_end   = {1'b0, widx} + {5'b0, need80};
    assign pad_final = (pad_end <= 6'd14);

    assign bus.msg_inpt_rdy    = (state == S_LOAD);
    assign bus.cmprss_otpt_res = res;
    assign bus.cmprss_otpt_vld = res_vld;

    // A partial last word gets its 0x80 marker inserted right here, so padding
    // only has to place the marker itself when the message ended word-aligned.
    always_comb begin
        in_word  = bus.msg_inpt_d;
        in_bytes = 4'd4;
        case (bus.msg_inpt_vld_byte)
            4'b1110: begin in_word = {bus.msg_inpt_d[31:8], 8'h80};          in_bytes = 4'd3; end
            4'b1100: begin in_word = {bus.msg_inpt_d[31:16], 16'h8000};      in_bytes = 4'd2; end
            4'b1000: begin in_word = {bus.msg_inpt_d[31:24], 24'h80_0000};   in_bytes = 4'd1; end
            default: begin in_word = bus.msg_inpt_d;                         in_bytes = 4'd4; end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (accept && bus.msg_inpt_lst)
                    state_nxt = S_PAD;
                else if (accept && widx == 5'd15)
                    state_nxt = S_CMPRS;
            end
            S_PAD:   state_nxt = S_CMPRS;
            S_CMPRS: begin
                if (rnd == 7'd64) begin
                    if (final_blk)
                        state_nxt = S_DONE;
                    else if (msg_end)
                        state_nxt = S_PAD;
                    else
                        state_nxt = S_LOAD;
                end
            end
            S_DONE:  state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    // blk doubles as the 16-word expansion window: blk[0] is W(j), blk[4] is W(j+4).
    always_comb begin
        tj    = (rnd < 7'd16) ? 32'h79cc4519 : 32'h7a879d8a;
        ss1   = rotl(rotl(r[0], 5'd12) + r[4] + rotl(tj, rnd[4:0]), 5'd7);
        ss2   = ss1 ^ rotl(r[0], 5'd12);
        ff    = (rnd < 7'd16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
        gg    = (rnd < 7'd16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
        tt1   = ff + r[3] + ss2 + (blk[0] ^ blk[4]);
        tt2   = gg + r[7] + ss1 + blk[0];
        w_new = p1(blk[0] ^ blk[7] ^ rotl(blk[13], 5'd15)) ^ rotl(blk[3], 5'd7) ^ blk[10];
    end

    always_ff @(posedge bus.clk or negedge bus.rst_n) begin
        if (!bus.rst_n) begin
            state     <= S_LOAD;
            widx      <= 5'd0;
            len       <= 64'd0;
            need80    <= 1'b0;
            msg_end   <= 1'b0;
            final_blk <= 1'b0;
            rnd       <= 7'd0;
            res       <= 256'd0;
            res_vld   <= 1'b0;
            for (int i = 0; i < 16; i++) blk[i] <= 32'd0;
            for (int i = 0; i < 8; i++) begin
                v[i] <= IV[255-32*i -: 32];
                r[i] <= 32'd0;
            end
        end else begin
            state   <= state_nxt;
            res_vld <= 1'b0;
            case (state)
                S_LOAD: begin
                    rnd <= 7'd0;
                    for (int i = 0; i < 8; i++) r[i] <= v[i];
                    if (accept) begin
                        blk[widx[3:0]] <= in_word;
                        widx           <= widx + 5'd1;
                        len            <= len + {57'd0, in_bytes, 3'b000};
                        if (bus.msg_inpt_lst) begin
                            msg_end <= 1'b1;
                            need80  <= (bus.msg_inpt_vld_byte == 4'b1111);
                        end
                    end
                end
                S_PAD: begin
                    rnd <= 7'd0;
                    for (int i = 0; i < 8; i++) r[i] <= v[i];
                    for (int i = 0; i < 16; i++) begin
                        if (5'(i) == widx && need80)
                            blk[i] <= 32'h8000_0000;
                        else if (5'(i) >= widx)
                            blk[i] <= 32'd0;
                    end
                    if (pad_final) begin
                        blk[14] <= len[63:32];
                        blk[15] <= len[31:0];
                    end
                    need80    <= need80 && (widx == 5'd16);
                    final_blk <= pad_final;
                end
                S_CMPRS: begin
                    rnd <= rnd + 7'd1;
                    if (rnd == 7'd64) begin
                        widx <= 5'd0;
                        for (int i = 0; i < 8; i++) v[i] <= v[i] ^ r[i];
                    end else begin
                        for (int i = 0; i < 15; i++) blk[i] <= blk[i+1];
                        blk[15] <= w_new;
                        r[0] <= tt1;
                        r[1] <= r[0];
                        r[2] <= rotl(r[1], 5'd9);
                        r[3] <= r[2];
                        r[4] <= p0(tt2);
                        r[5] <= r[4];
                        r[6] <= rotl(r[5], 5'd19);
                        r[7] <= r[6];
                    end
                end
                S_DONE: begin
                    res       <= {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
                    res_vld   <= 1'b1;
                    len       <= 64'd0;
                    widx      <= 5'd0;
                    need80    <= 1'b0;
                    msg_end   <= 1'b0;
                    final_blk <= 1'b0;
                    for (int i = 0; i < 8; i++) v[i] <= IV[255-32*i -: 32];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sm3_core_top.sv
// Self-checking bench for sm3_core_top: known vectors, random messages against a
// byte-level SM3 model, back-to-back messages and reset abort mid-compression.
module tb_sm3_core_top;
    localparam logic [255:0] IV_TB = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    typedef struct packed {
        logic [4:0]   n_words;
        logic [31:0]  word;
        logic [3:0]   last_mask;
        logic [7:0]   min_busy;
        logic [255:0] expected;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm3_if bus (.clk(clk), .rst_n(rst_n));
    sm3_core_top dut (.bus(bus));

    int           n_checks = 0;
    int           n_fail = 0;
    int           pulse_cnt = 0;
    logic         prev_vld = 1'b0;
    logic [7:0]   msg_q[$];
    logic [255:0] exp_q[$];
    logic [255:0] got_q[$];
    vec_t         vecs[2];

    function automatic logic [31:0] rl(input logic [31:0] x, input int s);
        int k = s % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    // Straight from the SM3 definition: pad the byte string, expand 68 words, 64 rounds per block.
    function automatic logic [255:0] ref_digest();
        logic [7:0]  p[$];
        logic [63:0] bl;
        logic [31:0] v[8];
        logic [31:0] w[68];
        logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, x;
        int          nblk;
        p  = msg_q;
        bl = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        for (int i = 0; i < 8; i++) v[i] = IV_TB[255-32*i -: 32];
        nblk = p.size() / 64;
        for (int bk = 0; bk < nblk; bk++) begin
            for (int j = 0; j < 16; j++)
                w[j] = {p[bk*64+4*j], p[bk*64+4*j+1], p[bk*64+4*j+2], p[bk*64+4*j+3]};
            for (int j = 16; j < 68; j++) begin
                x    = w[j-16] ^ w[j-9] ^ rl(w[j-3], 15);
                w[j] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(w[j-13], 7) ^ w[j-6];
            end
            a = v[0]; b = v[1]; c = v[2]; d = v[3]; e = v[4]; f = v[5]; g = v[6]; h = v[7];
            for (int j = 0; j < 64; j++) begin
                t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
                ss1 = rl(rl(a, 12) + e + rl(t, j % 32), 7);
                ss2 = ss1 ^ rl(a, 12);
                tt1 = ((j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c))) + d + ss2 + (w[j] ^ w[j+4]);
                tt2 = ((j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g))) + h + ss1 + w[j];
                d = c; c = rl(b, 9); b = a; a = tt1;
                h = g; g = rl(f, 19); f = e; e = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
            end
            v[0] ^= a; v[1] ^= b; v[2] ^= c; v[3] ^= d; v[4] ^= e; v[5] ^= f; v[6] ^= g; v[7] ^= h;
        end
        return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
    endfunction

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.cmprss_otpt_vld === 1'b1) begin
            pulse_cnt++;
            got_q.push_back(bus.cmprss_otpt_res);
            check_output("single_cycle_pulse", {255'd0, prev_vld}, 256'd0);
        end
        prev_vld = bus.cmprss_otpt_vld;
    end

    // Present one word once rdy is seen at a falling edge; it is taken on the next rising edge.
    task automatic apply_stimulus(input logic [31:0] d, input logic [3:0] m, input logic lst, input bit pulsed);
        int waited = 0;
        @(negedge clk);
        while (bus.msg_inpt_rdy !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (bus.msg_inpt_rdy !== 1'b1) begin
            bus.msg_inpt_vld = 1'b0;
            check_output("rdy_timeout", {255'd0, bus.msg_inpt_rdy}, 256'd1);
            return;
        end
        bus.msg_inpt_d        = d;
        bus.msg_inpt_vld_byte = m;
        bus.msg_inpt_lst      = lst;
        bus.msg_inpt_vld      = 1'b1;
        @(posedge clk);
        #1;
        if (pulsed || lst) begin
            bus.msg_inpt_vld = 1'b0;
            bus.msg_inpt_lst = 1'b0;
        end
    endtask

    task automatic send_message(input int nbytes, input bit pulsed);
        int          nw;
        logic [31:0] d;
        logic [3:0]  m;
        msg_q.delete();
        for (int i = 0; i < nbytes; i++) msg_q.push_back(8'($urandom));
        exp_q.push_back(ref_digest());
        nw = (nbytes + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            d = $urandom;
            for (int b = 0; b < 4; b++)
                if (4*k + b < nbytes) d[31-8*b -: 8] = msg_q[4*k+b];
            case (nbytes - 4*k)
                1:       m = 4'b1000;
                2:       m = 4'b1100;
                3:       m = 4'b1110;
                default: m = 4'b1111;
            endcase
            apply_stimulus(d, m, (k == nw - 1), pulsed);
        end
    endtask

    task automatic measure_busy(output int c);
        c = 0;
        while (bus.msg_inpt_rdy !== 1'b1 && c < 1000) begin
            @(negedge clk);
            if (bus.msg_inpt_rdy !== 1'b1) c++;
        end
    endtask

    task automatic wait_digests(input int n, input string name);
        int c = 0;
        while (got_q.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (got_q.size() < n) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: got %0d digests, expected %0d", name, got_q.size(), n);
            got_q.delete();
            exp_q.delete();
        end else begin
            for (int i = 0; i < n; i++) check_output(name, got_q.pop_front(), exp_q.pop_front());
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busy, pc0, n;
        vecs[0] = '{5'd1, 32'h61626300, 4'b1110, 8'd65,
                    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0};
        vecs[1] = '{5'd16, 32'h61626364, 4'b1111, 8'd130,
                    256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732};

        bus.msg_inpt_d = 32'd0;
        bus.msg_inpt_vld_byte = 4'b1111;
        bus.msg_inpt_vld = 1'b0;
        bus.msg_inpt_lst = 1'b0;
        #12;
        check_output("reset_rdy", {255'd0, bus.msg_inpt_rdy}, 256'd1);
        check_output("reset_vld", {255'd0, bus.cmprss_otpt_vld}, 256'd0);
        check_output("reset_res", bus.cmprss_otpt_res, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer vectors, including the exact-64-byte case that needs a whole pad block.
        for (int t = 0; t < 2; t++) begin
            pc0 = pulse_cnt;
            for (int k = 0; k < int'(vecs[t].n_words); k++)
                apply_stimulus(vecs[t].word, (k == int'(vecs[t].n_words) - 1) ? vecs[t].last_mask : 4'b1111,
                               (k == int'(vecs[t].n_words) - 1), 1'b0);
            exp_q.push_back(vecs[t].expected);
            measure_busy(busy);
            check_output($sformatf("vec%0d_busy", t), {255'd0, busy >= int'(vecs[t].min_busy)}, 256'd1);
            wait_digests(1, $sformatf("vec%0d_digest", t));
            repeat (5) @(negedge clk);
            check_output($sformatf("vec%0d_pulses", t), 256'(pulse_cnt - pc0), 256'd1);
        end

        // Random lengths cycling through every final-word mask, one pulsed handshake per word.
        for (int i = 0; i < 12; i++) begin
            n = 4 * int'($urandom_range(2, 32)) + (i % 4) + ((i % 4 == 0) ? 4 : 0);
            if (n > 132) n = 132;
            pc0 = pulse_cnt;
            send_message(n, 1'b1);
            wait_digests(1, $sformatf("rand_len%0d", n));
            repeat (3) @(negedge clk);
            check_output($sformatf("rand_len%0d_pulses", n), 256'(pulse_cnt - pc0), 256'd1);
        end

        // 56..63 bytes leave no room for the length field, forcing a second pad block.
        for (int len = 56; len < 64; len++) begin
            send_message(len, 1'b1);
            measure_busy(busy);
            check_output($sformatf("two_blk%0d_busy", len), {255'd0, busy >= 130}, 256'd1);
            wait_digests(1, $sformatf("two_blk%0d", len));
        end

        pc0 = pulse_cnt;
        send_message(int'($urandom_range(20, 70)), 1'b0);
        send_message(int'($urandom_range(5, 40)), 1'b0);
        wait_digests(2, "back_to_back");
        repeat (3) @(negedge clk);
        check_output("back_to_back_pulses", 256'(pulse_cnt - pc0), 256'd2);

        // Abort during the compression of a full, unterminated block.
        pc0 = pulse_cnt;
        for (int k = 0; k < 16; k++) apply_stimulus($urandom, 4'b1111, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check_output("busy_before_abort", {255'd0, bus.msg_inpt_rdy}, 256'd0);
        rst_n = 1'b0;
        #1;
        check_output("abort_rdy", {255'd0, bus.msg_inpt_rdy}, 256'd1);
        check_output("abort_vld", {255'd0, bus.cmprss_otpt_vld}, 256'd0);
        bus.msg_inpt_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(vecs[0].word, vecs[0].last_mask, 1'b1, 1'b1);
        exp_q.push_back(vecs[0].expected);
        wait_digests(1, "abc_after_abort");
        repeat (3) @(negedge clk);
        check_output("abort_pulses", 256'(pulse_cnt - pc0), 256'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
